// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
//   LATENCY_DEF : default multiplier product latency in cycles
//   TAG_ID_W    : width of the requester id carried by a tag (supports up to 256 requesters)
//   tag_t       : one tag-pipeline stage {valid, id}
package mult_arb_pkg;

  localparam int unsigned LATENCY_DEF = 3;
  localparam int unsigned TAG_ID_W    = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter: picks the first eligible requester
// at or after ptr, wrapping modulo N.
//   elig   : in  N   eligible requesters
//   ptr    : in  IW  search start index
//   grant  : out N   one-hot grant (zero when nothing eligible)
//   winner : out IW  index of granted requester (zero when nothing eligible)
//   any    : out 1   some requester was granted
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any
);

  int unsigned idx;

  // First eligible requester in rotated order wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!any && elig[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier between N_REQ requesters. A round-robin
// arbiter issues at most one operand pair per cycle; a tag pipeline matching
// the multiplier latency routes each product into its owner's response slot.
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid / req_ready  : per-requester operand handshake (ready is the grant)
//   req_a, req_b           : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid / rsp_ready  : per-requester product handshake
//   rsp_y                  : packed products, requester i at [i*2*WIDTH +: 2*WIDTH]
//   mul_a, mul_b, mul_y    : connection to the external multiplier
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [N_REQ*2*WIDTH-1:0] rsp_y,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_y
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]    ptr;
  tag_t             tag_q [LATENCY];
  tag_t             tag_last;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant_raw;
  logic [IW-1:0]    winner;
  logic             any_raw;
  logic             gnt;

  assign tag_last = tag_q[LATENCY-1];

  // A requester is busy while it owns an in-flight tag or an unconsumed product.
  always_comb begin
    busy = rsp_valid;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        if (tag_q[s].valid && (tag_q[s].id == TAG_ID_W'(i))) busy[i] = 1'b1;
      end
    end
  end

  assign elig = req_valid & ~busy;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .elig   (elig),
    .ptr    (ptr),
    .grant  (grant_raw),
    .winner (winner),
    .any    (any_raw)
  );

  // No grant can be issued while reset is held.
  assign gnt       = any_raw & ~rst;
  assign req_ready = gnt ? grant_raw : '0;
  assign mul_a     = gnt ? req_a[32'(winner)*WIDTH +: WIDTH] : '0;
  assign mul_b     = gnt ? req_b[32'(winner)*WIDTH +: WIDTH] : '0;

  // Round-robin pointer moves past the winner on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt) begin
      ptr <= (32'(winner) == N_REQ - 1) ? '0 : winner + IW'(1);
    end
  end

  // Tag pipeline mirrors the multiplier's fixed latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: gnt, id: TAG_ID_W'(winner)};
      for (int unsigned s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Capture returning products; busy gating guarantees the slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (tag_last.valid && (tag_last.id == TAG_ID_W'(i))) begin
          rsp_valid[i]                     <= 1'b1;
          rsp_y[i*2*WIDTH +: 2*WIDTH]      <= mul_y;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i]                     <= 1'b0;
        end
      end
    end
  end

endmodule
